// File: rtl/dot_engine_pkg.sv
// Shared types and constant helpers for the row-by-vector dot engine.
package dot_engine_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;

   localparam int LIM_W = 128;

   function automatic int tree_levels(input int lanes);
      return $clog2(lanes);
   endfunction

   // Most positive ACC_W-bit signed value; the most negative is its bitwise inverse.
   function automatic logic signed [LIM_W-1:0] sat_max(input int acc_w);
      return (LIM_W'(1) << (acc_w - 1)) - LIM_W'(1);
   endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// Pairwise registered adder tree: one register level per tree level, valid travels alongside.
module pipelined_adder_tree #(
   parameter int LANES = 8,
   parameter int IN_W  = 64,
   localparam int LEVELS = $clog2(LANES),
   localparam int OUT_W  = IN_W + LEVELS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [LANES-1:0][IN_W-1:0]   in_data,
   output logic                         out_valid,
   output logic                         busy,
   output logic signed [OUT_W-1:0]      sum
);
   // Heap layout: node 0 is the root, node k sums children 2k+1 and 2k+2; the
   // last LANES positions are the sign-extended inputs.
   logic [LANES-1:0][OUT_W-1:0] leaf;
   logic [LANES-2:0][OUT_W-1:0] node, node_d;
   logic [LEVELS:1]             vld_pipe;

   for (genvar i = 0; i < LANES; i++) begin : g_leaf
      assign leaf[i] = {{LEVELS{in_data[i][IN_W-1]}}, in_data[i]};
   end

   for (genvar k = 0; k < LANES - 1; k++) begin : g_node
      localparam int C0 = 2 * k + 1;
      localparam int C1 = 2 * k + 2;
      if (C0 < LANES - 1) begin : g_inner
         assign node_d[k] = node[C0] + node[C1];
      end else begin : g_edge
         assign node_d[k] = leaf[C0-(LANES-1)] + leaf[C1-(LANES-1)];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         node     <= '0;
         vld_pipe <= '0;
      end else begin
         node        <= node_d;
         vld_pipe[1] <= in_valid;
         for (int s = 2; s <= LEVELS; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
   end

   assign sum       = node[0];
   assign out_valid = vld_pipe[LEVELS];
   assign busy      = |vld_pipe;

endmodule

// File: rtl/row_vector_dot_engine.sv
// Row-by-vector signed dot product: per-lane multiply, registered adder tree and
// a wrapping or saturating accumulator across num_chunks beats.
module row_vector_dot_engine
   import dot_engine_pkg::*;
#(
   parameter int NUM_LANES = 8,
   parameter int ELEM_W    = 32,
   parameter int ACC_W     = 48,
   parameter int CNT_W     = 16,
   parameter int SATURATE  = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [CNT_W-1:0]              num_chunks,
   output logic                          busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_LANES*ELEM_W-1:0]   a_row,
   input  logic [NUM_LANES*ELEM_W-1:0]   p_vec,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic signed [ACC_W-1:0]       result,
   output logic                          overflow
);
   localparam int TREE_LEVELS = tree_levels(NUM_LANES);
   localparam int PROD_W = 2 * ELEM_W;
   localparam int SUM_W  = PROD_W + TREE_LEVELS;
   // The add is done wide enough for both operands plus a carry so overflow is exact.
   localparam int ADD_W  = (ACC_W > SUM_W ? ACC_W : SUM_W) + 1;
   localparam logic [LIM_W-1:0]        MAX_FULL = sat_max(ACC_W);
   localparam logic signed [ACC_W-1:0] ACC_MAX  = MAX_FULL[ACC_W-1:0];
   localparam logic signed [ACC_W-1:0] ACC_MIN  = ~ACC_MAX;

   state_t state, state_d;
   logic [CNT_W-1:0] cnt;
   logic beat, row_start;
   logic [NUM_LANES-1:0][PROD_W-1:0] prod, prod_next;
   logic m_vld, tree_vld, tree_busy, acc_vld, ovf, fits;
   logic signed [SUM_W-1:0] tree_sum;
   logic signed [ACC_W-1:0] acc, acc_next;
   logic signed [ADD_W-1:0] wide_sum;
   logic [ADD_W-ACC_W:0]    hi;

   assign beat      = in_valid && in_ready;
   assign row_start = (state == IDLE) && start;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic signed [ELEM_W-1:0] a_e, p_e;
      logic signed [PROD_W-1:0] prod_d;
      assign a_e          = a_row[i*ELEM_W +: ELEM_W];
      assign p_e          = p_vec[i*ELEM_W +: ELEM_W];
      assign prod_d       = a_e * p_e;
      assign prod_next[i] = prod_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod  <= '0;
         m_vld <= 1'b0;
      end else begin
         prod  <= prod_next;
         m_vld <= beat;
      end
   end

   pipelined_adder_tree #(.LANES(NUM_LANES), .IN_W(PROD_W)) u_tree (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (m_vld),
      .in_data   (prod),
      .out_valid (tree_vld),
      .busy      (tree_busy),
      .sum       (tree_sum)
   );

   assign wide_sum = {{(ADD_W-ACC_W){acc[ACC_W-1]}}, acc}
                   + {{(ADD_W-SUM_W){tree_sum[SUM_W-1]}}, tree_sum};
   assign hi   = wide_sum[ADD_W-1:ACC_W-1];
   assign fits = (hi == '0) || (&hi);

   always_comb begin
      acc_next = wide_sum[ACC_W-1:0];
      if (SATURATE != 0 && !fits) acc_next = wide_sum[ADD_W-1] ? ACC_MIN : ACC_MAX;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         ovf     <= 1'b0;
         acc_vld <= 1'b0;
         cnt     <= '0;
      end else begin
         acc_vld <= tree_vld;
         if (row_start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= num_chunks;
         end else begin
            if (tree_vld) begin
               acc <= acc_next;
               if (!fits) ovf <= 1'b1;
            end
            if (beat) cnt <= cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // DRAIN ends on the cycle after the last beat lands, with nothing left in flight.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (start) state_d = (num_chunks == '0) ? HOLD : LOAD;
         LOAD:    if (beat && cnt == CNT_W'(1)) state_d = DRAIN;
         DRAIN:   if (acc_vld && !m_vld && !tree_busy) state_d = HOLD;
         HOLD:    if (result_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy         = (state != IDLE);
   assign in_ready     = (state == LOAD);
   assign result_valid = (state == HOLD);
   assign result       = acc;
   assign overflow     = ovf;

endmodule

// File: tb/tb_row_vector_dot_engine.sv
// Directed bench: wrapping and saturating engines side by side against a row-level model.
module tb_row_vector_dot_engine;
   localparam int NL = 8, EW = 32, AW = 48, CW = 16;

   logic clk = 1'b0;
   logic reset, start, in_valid, result_ready;
   logic [CW-1:0] num_chunks;
   logic [NL*EW-1:0] a_row, p_vec;
   logic busy_w, in_ready_w, rv_w, ovf_w;
   logic busy_s, in_ready_s, rv_s, ovf_s;
   logic signed [AW-1:0] res_w, res_s;

   int checks = 0, errors = 0;
   bit exp_pending = 1'b0;
   logic signed [AW-1:0] exp_w, exp_s;
   logic exp_ow, exp_os;
   logic [NL*EW-1:0] beat_a [16];
   logic [NL*EW-1:0] beat_p [16];

   always #5 clk = ~clk;

   row_vector_dot_engine #(.NUM_LANES(NL), .ELEM_W(EW), .ACC_W(AW), .CNT_W(CW), .SATURATE(0)) dut_w (
      .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks), .busy(busy_w),
      .in_valid(in_valid), .in_ready(in_ready_w), .a_row(a_row), .p_vec(p_vec),
      .result_valid(rv_w), .result_ready(result_ready), .result(res_w), .overflow(ovf_w));

   row_vector_dot_engine #(.NUM_LANES(NL), .ELEM_W(EW), .ACC_W(AW), .CNT_W(CW), .SATURATE(1)) dut_s (
      .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks), .busy(busy_s),
      .in_valid(in_valid), .in_ready(in_ready_s), .a_row(a_row), .p_vec(p_vec),
      .result_valid(rv_s), .result_ready(result_ready), .result(res_s), .overflow(ovf_s));

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill(input int idx, input int a0, input int astep, input int pv);
      for (int i = 0; i < NL; i++) begin
         beat_a[idx][i*EW +: EW] = a0 + i * astep;
         beat_p[idx][i*EW +: EW] = pv;
      end
   endtask

   // Row-level model: exact dot product per beat, then wrap or clamp into 48 bits.
   task automatic model_row(input int n, output logic signed [AW-1:0] rw, output logic ow,
                            output logic signed [AW-1:0] rs, output logic os);
      logic signed [127:0] aw, as_, bs, mx, mn;
      longint av, pv;
      mx = (128'sd1 <<< (AW - 1)) - 128'sd1;
      mn = -(128'sd1 <<< (AW - 1));
      aw = 0; as_ = 0; ow = 0; os = 0;
      for (int b = 0; b < n; b++) begin
         bs = 0;
         for (int i = 0; i < NL; i++) begin
            av = longint'($signed(beat_a[b][i*EW +: EW]));
            pv = longint'($signed(beat_p[b][i*EW +: EW]));
            bs = bs + av * pv;
         end
         aw = aw + bs;
         if (aw > mx || aw < mn) begin
            ow = 1'b1;
            aw = {{(128-AW){aw[AW-1]}}, aw[AW-1:0]};
         end
         as_ = as_ + bs;
         if (as_ > mx) begin as_ = mx; os = 1'b1; end
         else if (as_ < mn) begin as_ = mn; os = 1'b1; end
      end
      rw = aw[AW-1:0];
      rs = as_[AW-1:0];
   endtask

   // Compare process: whenever a result is presented it must match the model.
   always @(negedge clk) begin
      if (!reset && (rv_w || rv_s)) begin
         if (!exp_pending) begin
            check("spurious_result_valid", {rv_s, rv_w}, 0);
         end else begin
            check("cmp_rv_pair", {rv_s, rv_w}, 2'b11);
            check("cmp_result_wrap", res_w, exp_w);
            check("cmp_ovf_wrap", ovf_w, exp_ow);
            check("cmp_result_sat", res_s, exp_s);
            check("cmp_ovf_sat", ovf_s, exp_os);
         end
      end
   end

   task automatic run_row(input string tag, input int n, input int gap,
                          input logic signed [AW-1:0] lit_w, input logic lit_ow,
                          input logic signed [AW-1:0] lit_s, input logic lit_os,
                          input int lat_exp, input int hold, input bit start_in_load,
                          input bit start_in_hold, input bit start_with_accept);
      logic signed [AW-1:0] mw, ms;
      logic mow, mos, rdy;
      int lat, tries;
      model_row(n, mw, mow, ms, mos);
      check({tag, "_model_wrap"}, mw, lit_w);
      check({tag, "_model_sat"}, ms, lit_s);
      exp_w = mw; exp_ow = mow; exp_s = ms; exp_os = mos; exp_pending = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; num_chunks = CW'(n);
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < n; b++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1; a_row = beat_a[b]; p_vec = beat_p[b];
         tries = 0;
         do begin
            @(negedge clk); rdy = in_ready_w;
            @(posedge clk); #1;
            tries++;
         end while (!rdy && tries < 20);
         if (!rdy) check({tag, "_beat_accept_timeout"}, 0, 1);
         in_valid = 1'b0;
         if (b == 0 && start_in_load && n > 1) begin
            start = 1'b1; num_chunks = 5;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) check({tag, "_in_ready_low"}, {in_ready_s, in_ready_w}, 0);
         if (rv_w) begin lat = k; break; end
      end
      check({tag, "_latency"}, lat, lat_exp);
      check({tag, "_result_wrap"}, res_w, lit_w);
      check({tag, "_ovf_wrap"}, ovf_w, lit_ow);
      check({tag, "_result_sat"}, res_s, lit_s);
      check({tag, "_ovf_sat"}, ovf_s, lit_os);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         start = (h == 2) && start_in_hold;
         num_chunks = 4;
      end
      @(posedge clk); #1;
      start = start_with_accept; num_chunks = 3;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0; start = 1'b0; exp_pending = 1'b0;
      @(negedge clk);
      check({tag, "_rv_dropped"}, {rv_s, rv_w}, 0);
      check({tag, "_idle_after"}, {busy_s, busy_w}, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
      num_chunks = '0; a_row = '0; p_vec = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {busy_w, in_ready_w, rv_w, ovf_w, busy_s, in_ready_s, rv_s, ovf_s}, 0);
      check("reset_result", {res_w, res_s}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      fill(0, 1, 1, 1);
      run_row("one_beat", 1, 0, 48'sd36, 1'b0, 48'sd36, 1'b0, 6, 3, 0, 0, 0);

      for (int b = 0; b < 3; b++) fill(b, -2, 0, 5);
      run_row("gapped", 3, 2, -48'sd240, 1'b0, -48'sd240, 1'b0, 6, 1, 0, 0, 0);

      run_row("zero_chunks", 0, 0, 48'sd0, 1'b0, 48'sd0, 1'b0, 1, 1, 0, 0, 0);

      for (int b = 0; b < 4; b++) fill(b, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF);
      run_row("overflow", 4, 0, -48'sd137438953440, 1'b1, 48'sd140737488355327, 1'b1, 6, 2, 0, 0, 0);

      // Abort a 3-beat row after two beats; no result may ever appear for it.
      for (int b = 0; b < 3; b++) fill(b, 100, 0, 100);
      @(posedge clk); #1;
      start = 1'b1; num_chunks = 3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; a_row = beat_a[b]; p_vec = beat_p[b];
         @(posedge clk); #1;
      end
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", {busy_s, busy_w}, 0);
      check("abort_rv", {rv_s, rv_w}, 0);
      repeat (12) @(posedge clk);
      #1;
      fill(0, 1, 0, 1);
      run_row("after_abort", 1, 0, 48'sd8, 1'b0, 48'sd8, 1'b0, 6, 1, 0, 0, 0);

      for (int b = 0; b < 2; b++) fill(b, 1, 1, -3);
      run_row("ignored_starts", 2, 0, -48'sd216, 1'b0, -48'sd216, 1'b0, 6, 10, 1, 1, 1);

      run_row("next_row", 0, 0, 48'sd0, 1'b0, 48'sd0, 1'b0, 1, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
